// File: rtl/chroma_key_mp.sv
// Chroma-key stage for the HSV path: keys a hue/saturation window to a
// generated rainbow background, with frame-synchronous config and counting.
module chroma_key_mp #(
    parameter int ROW_W       = 13,
    parameter int COL_W       = 13,
    parameter int PASS_W      = 24,
    parameter int HUE_LO_DEF  = 90,
    parameter int HUE_HI_DEF  = 150,
    parameter int SAT_MIN_DEF = 50,
    parameter int SCROLL_STEP = 1,
    parameter int CNT_W       = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [23:0]       pixel_in,
    input  logic [PASS_W-1:0] pass_in,
    input  logic              key_en,
    input  logic              animate,
    input  logic [3:0]        bg_sel,
    input  logic [8:0]        hue_lo_in,
    input  logic [8:0]        hue_hi_in,
    input  logic [6:0]        sat_min_in,
    output logic [23:0]       pixel_out,
    output logic [PASS_W-1:0] pass_thru,
    output logic              out_valid,
    output logic [CNT_W-1:0]  key_count,
    output logic              count_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        pend_sel, act_sel, sel, pend_nxt;
    logic [8:0]        act_lo, act_hi, lo, hi, phase, phase_nxt;
    logic [6:0]        act_sat, smin;
    logic [8:0]        hue, r_mod, c_mod, bg;
    logic [6:0]        sat;
    logic [10:0]       bg_sum;
    logic [9:0]        phase_sum;
    logic              fs, in_win, key;
    logic [CNT_W-1:0]  cnt;
    logic              key_q, vld_q;
    logic [8:0]        bg_q;
    logic [23:0]       pix_q;
    logic [PASS_W-1:0] pass_q;

    assign hue = pixel_in[23:15];
    assign sat = pixel_in[14:8];
    assign fs  = in_valid && (row == '0) && (col == '0);

    // The FS pixel sees the newly loaded settings, so bypass the shadow regs.
    assign sel  = fs ? pend_sel   : act_sel;
    assign lo   = fs ? hue_lo_in  : act_lo;
    assign hi   = fs ? hue_hi_in  : act_hi;
    assign smin = fs ? sat_min_in : act_sat;

    assign in_win = (lo <= hi) ? (hue >= lo && hue <= hi)
                               : (hue >= lo || hue <= hi);
    assign key = in_valid && key_en && (hue <= 9'd359)
                 && (sat >= smin) && in_win;

    assign r_mod = 9'(32'(row) % 32'd360);
    assign c_mod = 9'(32'(col) % 32'd360);

    always_comb begin
        bg_sum = '0;
        unique case (sel)
            2'd0: bg_sum = 11'(r_mod) + 11'(c_mod) + 11'(phase);
            2'd1: bg_sum = 11'(r_mod) + 11'd360 - 11'(c_mod) + 11'(phase);
            2'd2: bg_sum = 11'(r_mod) + 11'(phase);
            2'd3: bg_sum = 11'(c_mod) + 11'(phase);
        endcase
    end

    // Every operand is already below 360, so two subtractions suffice.
    always_comb begin
        if (bg_sum >= 11'd720)
            bg = 9'(bg_sum - 11'd720);
        else if (bg_sum >= 11'd360)
            bg = 9'(bg_sum - 11'd360);
        else
            bg = 9'(bg_sum);
    end

    always_comb begin
        pend_nxt = pend_sel;
        case (bg_sel)
            4'b0001: pend_nxt = 2'd0;
            4'b0010: pend_nxt = 2'd1;
            4'b0100: pend_nxt = 2'd2;
            4'b1000: pend_nxt = 2'd3;
            default: pend_nxt = pend_sel;
        endcase
    end

    assign phase_sum = 10'(phase) + 10'(SCROLL_STEP);
    assign phase_nxt = (phase_sum >= 10'd360) ? 9'(phase_sum - 10'd360)
                                              : 9'(phase_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_sel    <= '0;
            act_sel     <= '0;
            act_lo      <= 9'(HUE_LO_DEF);
            act_hi      <= 9'(HUE_HI_DEF);
            act_sat     <= 7'(SAT_MIN_DEF);
            phase       <= '0;
            cnt         <= '0;
            key_count   <= '0;
            count_valid <= 1'b0;
            key_q       <= 1'b0;
            vld_q       <= 1'b0;
            bg_q        <= '0;
            pix_q       <= '0;
            pass_q      <= '0;
            pixel_out   <= '0;
            pass_thru   <= '0;
            out_valid   <= 1'b0;
        end else begin
            pend_sel    <= pend_nxt;
            count_valid <= 1'b0;
            if (fs) begin
                act_sel     <= pend_sel;
                act_lo      <= hue_lo_in;
                act_hi      <= hue_hi_in;
                act_sat     <= sat_min_in;
                if (animate)
                    phase <= phase_nxt;
                key_count   <= cnt;
                count_valid <= 1'b1;
                cnt         <= {{(CNT_W-1){1'b0}}, key};
            end else if (key && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            key_q     <= key;
            vld_q     <= in_valid;
            bg_q      <= bg;
            pix_q     <= pixel_in;
            pass_q    <= pass_in;
            pixel_out <= key_q ? {bg_q, 7'h7F, 8'hFF} : pix_q;
            pass_thru <= pass_q;
            out_valid <= vld_q;
        end
    end

endmodule

// File: tb/tb_chroma_key_mp.sv
// Scoreboard bench for chroma_key_mp: expected pixels are queued at drive
// time and compared when out_valid appears; tasks check config and counters.
module tb_chroma_key_mp;

    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [12:0]   row = '0;
    logic [12:0]   col = '0;
    logic [23:0]   pixel_in = '0;
    logic [PW-1:0] pass_in = '0;
    logic          key_en = 1'b1;
    logic          animate = 1'b0;
    logic [3:0]    bg_sel = '0;
    logic [8:0]    hue_lo_in = 9'd90;
    logic [8:0]    hue_hi_in = 9'd150;
    logic [6:0]    sat_min_in = 7'd50;

    logic [23:0]   pixel_out, pixel_out4;
    logic [PW-1:0] pass_thru, pass_thru4;
    logic          out_valid, out_valid4;
    logic [21:0]   key_count;
    logic [3:0]    key_count4;
    logic          count_valid, count_valid4;

    logic [47:0]   sb_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    chroma_key_mp dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .row(row), .col(col),
        .pixel_in(pixel_in), .pass_in(pass_in), .key_en(key_en),
        .animate(animate), .bg_sel(bg_sel), .hue_lo_in(hue_lo_in),
        .hue_hi_in(hue_hi_in), .sat_min_in(sat_min_in),
        .pixel_out(pixel_out), .pass_thru(pass_thru), .out_valid(out_valid),
        .key_count(key_count), .count_valid(count_valid)
    );

    chroma_key_mp #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .row(row), .col(col),
        .pixel_in(pixel_in), .pass_in(pass_in), .key_en(key_en),
        .animate(animate), .bg_sel(bg_sel), .hue_lo_in(hue_lo_in),
        .hue_hi_in(hue_hi_in), .sat_min_in(sat_min_in),
        .pixel_out(pixel_out4), .pass_thru(pass_thru4),
        .out_valid(out_valid4), .key_count(key_count4),
        .count_valid(count_valid4)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(int h, int s, int v);
        return {9'(h), 7'(s), 8'(v)};
    endfunction

    function automatic logic [23:0] kp(int b);
        return {9'(b), 7'h7F, 8'hFF};
    endfunction

    always @(negedge clk) begin
        logic [47:0] e;
        if (!rst && out_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_extra: got pixel %h, wanted no output",
                         pixel_out);
            end else begin
                e = sb_q.pop_front();
                if ({pixel_out, pass_thru} !== e)
                    $display("FAIL sb_pixel: got %h/%h want %h/%h",
                             pixel_out, pass_thru, e[47:24], e[23:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive(input logic v, input int r, input int c,
                         input logic [23:0] px, input logic [23:0] ex);
        in_valid = v;
        row      = 13'(r);
        col      = 13'(c);
        pixel_in = px;
        pass_in  = PW'($urandom);
        if (v)
            sb_q.push_back({ex, pass_in});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pixel_in = 24'hABCDEF;
        pass_in = 24'h123456;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pixel_out, pass_thru, out_valid, key_count, count_valid} !== '0)
            $display("FAIL rst_outs: got %h/%h/%b/%0d/%b want zeros",
                     pixel_out, pass_thru, out_valid, key_count, count_valid);
        else n_pass++;
        n_checks++;
        if ({pixel_out4, pass_thru4, out_valid4, key_count4,
             count_valid4} !== '0)
            $display("FAIL rst_outs4: got %h/%h/%b/%0d/%b want zeros",
                     pixel_out4, pass_thru4, out_valid4, key_count4,
                     count_valid4);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_release_ov: got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_defaults;
        drive(1, 10, 20, mk(120, 60, 8'h33), kp(30));
        drive(1, 10, 20, mk(89, 60, 8'h34), mk(89, 60, 8'h34));
        drive(1, 10, 20, mk(120, 49, 8'h35), mk(120, 49, 8'h35));
        drive(1, 10, 20, mk(150, 50, 8'h36), kp(30));
        drive(1, 10, 20, mk(90, 127, 8'h37), kp(30));
        drive(1, 10, 20, mk(151, 60, 8'h38), mk(151, 60, 8'h38));
    endtask

    task automatic test_wrap;
        hue_lo_in = 9'd340; hue_hi_in = 9'd20; sat_min_in = 7'd10;
        drive(1, 0, 0, mk(10, 20, 1), kp(0));
        n_checks++;
        if (count_valid !== 1'b1 || key_count !== 22'd3)
            $display("FAIL wrap_fs_count: got %b/%0d want 1/3",
                     count_valid, key_count);
        else n_pass++;
        hue_lo_in = 9'd90; hue_hi_in = 9'd150; sat_min_in = 7'd50;
        drive(1, 1, 2, mk(350, 20, 2), kp(3));
        n_checks++;
        if (count_valid !== 1'b0)
            $display("FAIL wrap_cv_pulse: got %b want 0", count_valid);
        else n_pass++;
        drive(1, 1, 2, mk(5, 20, 3), kp(3));
        drive(1, 1, 2, mk(21, 20, 4), mk(21, 20, 4));
        drive(1, 1, 2, mk(400, 20, 5), mk(400, 20, 5));
        drive(1, 1, 2, mk(340, 9, 6), mk(340, 9, 6));
        drive(1, 1, 2, mk(340, 10, 7), kp(3));
        drive(1, 1, 2, mk(20, 10, 8), kp(3));
        key_en = 1'b0;
        drive(1, 1, 2, mk(350, 20, 9), mk(350, 20, 9));
        key_en = 1'b1;
    endtask

    task automatic test_select;
        bg_sel = 4'b0100;
        drive(1, 1, 2, mk(350, 20, 1), kp(3));
        bg_sel = 4'b0000;
        drive(1, 1, 2, mk(350, 20, 2), kp(3));
        bg_sel = 4'b0110;
        idle(1);
        hue_lo_in = 9'd0; hue_hi_in = 9'd359; sat_min_in = 7'd0;
        bg_sel = 4'b1000;
        drive(1, 0, 0, mk(100, 60, 3), kp(0));
        bg_sel = 4'b0000;
        drive(1, 400, 7, mk(200, 0, 4), kp(40));
        drive(1, 400, 7, mk(359, 0, 5), kp(40));
        drive(1, 0, 0, mk(100, 60, 6), kp(0));
        drive(1, 3, 725, mk(100, 60, 7), kp(5));
        bg_sel = 4'b0010;
        idle(1);
        bg_sel = 4'b0000;
        drive(1, 0, 0, mk(100, 60, 8), kp(0));
        drive(1, 5, 10, mk(100, 60, 9), kp(355));
        drive(1, 8000, 3, mk(100, 60, 10), kp(77));
        drive(1, 0, 8191, mk(100, 60, 11), kp(89));
    endtask

    task automatic test_animate;
        bg_sel = 4'b0001;
        idle(1);
        bg_sel = 4'b0000;
        animate = 1'b1;
        for (int k = 0; k <= 360; k++)
            drive(1, 0, 0, mk(100, 60, k), kp(k % 360));
        animate = 1'b0;
        drive(1, 0, 0, mk(100, 60, 1), kp(1));
        drive(1, 0, 0, mk(100, 60, 2), kp(1));
        drive(1, 8191, 8191, mk(100, 60, 3), kp(183));
    endtask

    task automatic test_counter;
        hue_lo_in = 9'd90; hue_hi_in = 9'd150; sat_min_in = 7'd50;
        drive(1, 0, 0, mk(10, 60, 0), mk(10, 60, 0));
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 1, mk(100, 60, i), kp(3));
            if (i % 10 == 0) begin
                drive(0, 1, 1, mk(100, 60, 0), '0);
                drive(1, 1, 1, mk(151, 60, i), mk(151, 60, i));
            end
        end
        drive(1, 0, 0, mk(10, 60, 0), mk(10, 60, 0));
        n_checks++;
        if (count_valid !== 1'b1 || key_count !== 22'd100)
            $display("FAIL cnt_100: got %b/%0d want 1/100",
                     count_valid, key_count);
        else n_pass++;
        n_checks++;
        if (count_valid4 !== 1'b1 || key_count4 !== 4'd15)
            $display("FAIL cnt4_sat100: got %b/%0d want 1/15",
                     count_valid4, key_count4);
        else n_pass++;
        drive(0, 1, 1, mk(100, 60, 0), '0);
        n_checks++;
        if (count_valid !== 1'b0 || count_valid4 !== 1'b0)
            $display("FAIL cnt_pulse: got %b/%b want 0/0",
                     count_valid, count_valid4);
        else n_pass++;
        for (int i = 0; i < 20; i++)
            drive(1, 1, 1, mk(120, 60, i), kp(3));
        drive(1, 0, 0, mk(100, 60, 0), kp(1));
        n_checks++;
        if (key_count !== 22'd20 || key_count4 !== 4'd15)
            $display("FAIL cnt_20: got %0d/%0d want 20/15",
                     key_count, key_count4);
        else n_pass++;
        for (int i = 0; i < 4; i++)
            drive(1, 1, 1, mk(120, 60, i), kp(3));
        drive(1, 0, 0, mk(10, 60, 0), mk(10, 60, 0));
        n_checks++;
        if (key_count !== 22'd5 || key_count4 !== 4'd5)
            $display("FAIL cnt_fs_keyed: got %0d/%0d want 5/5",
                     key_count, key_count4);
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        drive(1, 0, 0, mk(10, 60, 0), mk(10, 60, 0));
        drive(1, 1, 1, mk(100, 60, 1), kp(3));
        drive(1, 1, 1, mk(100, 60, 2), kp(3));
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || pixel_out !== 24'h0)
            $display("FAIL rst_mid_flush: got %b/%h want 0/000000",
                     out_valid, pixel_out);
        else n_pass++;
        sb_q.delete();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_mid_release: got %b want 0", out_valid);
        else n_pass++;
        drive(1, 0, 0, mk(10, 60, 0), mk(10, 60, 0));
        n_checks++;
        if (count_valid !== 1'b1 || key_count !== 22'd0)
            $display("FAIL rst_mid_count: got %b/%0d want 1/0",
                     count_valid, key_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_wrap();
        test_select();
        test_animate();
        test_counter();
        test_rst_mid();
        idle(4);
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chroma_key_mp.md
# chroma_key_mp

Parametrised chroma-key stage for the HSV video path: replaces pixels whose hue/saturation fall inside a programmable key window with a generated rainbow background, and carries a sideband word through with matched latency. It is the next generation of the fixed green-screen stage. It adds:
- runtime thresholds with a wrap-around hue window
- frame-synchronous configuration and background-select shadowing
- an animated (scrolling) background phase
- a per-frame keyed-pixel counter

It sits between the RGB→HSV converter and the HSV→RGB converter.

## Interface
- ROW_W, 13, row index width
- COL_W, 13, column index width
- PASS_W, 24, sideband width
- HUE_LO_DEF, 90, reset value of active hue low bound
- HUE_HI_DEF, 150, reset value of active hue high bound
- SAT_MIN_DEF, 50, reset value of active saturation minimum
- SCROLL_STEP, 1, phase increment per frame (1..359)
- CNT_W, 22, key counter width

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel qualifier
- row  in  ROW_W  pixel row
- col  in  COL_W  pixel column
- pixel_in  in  24  {hue[8:0] 0..359, sat[6:0], val[7:0]}
- pass_in  in  PASS_W  sideband
- key_en  in  1  keying enable
- animate  in  1  enable per-frame phase advance
- bg_sel  in  4  one-hot background request
- hue_lo_in, hue_hi_in  in  9  requested hue bounds
- sat_min_in  in  7  requested saturation minimum
- pixel_out  out  24  keyed pixel
- pass_thru  out  PASS_W  sideband, latency-matched
- out_valid  out  1  in_valid delayed 2
- key_count  out  CNT_W  keyed-pixel count of the last completed frame
- count_valid  out  1  one-cycle pulse when key_count updates

## Operation
- Frame start (FS): in_valid=1 and row=0 and col=0.
- Pending select:
  - every cycle, a one-hot bg_sel loads pend_sel (0001→0, 0010→1, 0100→2, 1000→3)
  - any non-one-hot value, including 0000, leaves pend_sel unchanged
- At FS:
  - act_sel ← pend_sel
  - act_lo/hi/sat ← hue_lo_in/hue_hi_in/sat_min_in
  - the FS pixel itself is evaluated with these new values (combinational bypass)
- Phase:
  - the FS pixel and the rest of its frame use the current phase register
  - at FS, if animate=1, phase ← (phase + SCROLL_STEP) mod 360; else phase holds
- Key test (valid pixel, key_en=1), all three must hold:
  - hue ≤ 359
  - sat ≥ act_sat
  - hue in window:
    - if act_lo ≤ act_hi: act_lo ≤ hue ≤ act_hi
    - if act_lo > act_hi (wrap): hue ≥ act_lo or hue ≤ act_hi
- Background hue bg, by act_sel (exact mathematical mod, result 0..359):
  - 0: (row + col + phase) mod 360
  - 1: (row − col + phase) mod 360, non-negative
  - 2: (row + phase) mod 360
  - 3: (col + phase) mod 360
- Output:
  - keyed → {bg, 7'h7F, 8'hFF}
  - else → pixel_in unchanged
  - key_en=0 → never keyed
- Counter:
  - each valid keyed pixel increments cnt, saturating at 2^CNT_W−1
  - at FS: key_count ← cnt, count_valid=1 next cycle, and cnt ← (FS pixel keyed ? 1 : 0)
- Reset values:
  - pixel_out = 0, pass_thru = 0, out_valid = 0, key_count = 0, count_valid = 0
  - cnt = 0, phase = 0, pend_sel = act_sel = 0
  - act_lo/hi/sat = HUE_LO_DEF/HUE_HI_DEF/SAT_MIN_DEF
- Reset mid-frame discards in-flight pixels and the partial count. The first FS after reset reports key_count=0.

## Timing
- Two-stage pipeline, latency exactly 2 cycles from input to pixel_out/pass_thru/out_valid.
  - Stage 1 registers: key decision, bg, pixel_in, pass_in, in_valid.
  - Stage 2 registers: the output mux.
- The pipeline advances every cycle with no stall. Data registers load even when in_valid=0; consumers qualify with out_valid.
- count_valid is asserted the cycle after FS is sampled. It is independent of the pixel pipeline.
- Simultaneous FS and bg_sel change: the FS cycle loads pend_sel→act_sel using the old pend_sel. A new one-hot bg_sel seen on the FS cycle takes effect at the next FS.
- rst has priority over all events, including FS. The first cycle after rst deasserts shows out_valid=0.

## Test plan
- Reset defaults: pixel hue=120, sat=60, row=10, col=20, key_en=1, act_sel=0, phase=0 → after 2 cycles pixel_out={9'd30,7'h7F,8'hFF}. Hue=89 → pixel passes unchanged.
- Wrap window: FS with hue_lo_in=340, hue_hi_in=20, sat_min_in=10. Then hue 350, 5, 21 (sat 20) → first two keyed, third unchanged. Hue 400 → never keyed.
- Select shadowing: mid-frame bg_sel=0100 then 0000 → frame unchanged. Next FS uses mode 2: row=400, col=7 → bg=40. bg_sel=0110 ignored.
- Animation: animate=1, SCROLL_STEP=1 → frame k (FS pixel row=0, col=0, mode 0) keyed output hue = k mod 360. Check k=0,1,359,360. animate=0 → phase frozen.
- Counter: 100 keyed valid pixels, plus keyed pixels with in_valid=0 → next FS gives key_count=100 with a one-cycle count_valid. CNT_W=4 with 20 keyed pixels → 15.
- Reset mid-frame: assert rst with 2 pixels in flight → out_valid=0 and pixel_out=0 the cycle after. Next FS reports key_count=0. pass_thru is always pass_in delayed 2.
